instr_fetch_decode: RTL and testbench
=====================================

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port oAddress, output, 16 bits: program counter, wired to the instruction ROM address input.
REQ-004 SHALL have port iInstruction, input, 28 bits: combinational ROM data for the current oAddress.
REQ-005 SHALL have port iStall, input, 1 bit: downstream busy (e.g. LCD/LED write pending); holds all state.
REQ-006 SHALL have port iBranchTaken, input, 1 bit: execute stage resolved a taken BLE/JMP this cycle.
REQ-007 SHALL have port iBranchTarget, input, 16 bits: new PC, valid when iBranchTaken=1.
REQ-008 SHALL have port oValid, output, 1 bit: the decoded outputs hold a real instruction this cycle.
REQ-009 SHALL have port oOperation, output, 4 bits: opcode field.
REQ-010 SHALL have port oDestination, output, 8 bits: destination field.
REQ-011 SHALL have port oSourceA, output, 8 bits: source A field.
REQ-012 SHALL have port oSourceB, output, 8 bits: source B field.
REQ-013 SHALL have port oLiteral, output, 16 bits: immediate field (STO/NOP literal).
REQ-014 SHALL have port oInstrAddress, output, 16 bits: ROM address the current decoded instruction came from.

Function
REQ-015 Field split SHALL be: opcode [27:24], destination [23:16], source A [15:8], source B [7:0], literal [15:0]; all outputs are driven from one 28-bit instruction register (IR), with no combinational path from iInstruction.
REQ-016 The FSM SHALL have states IDLE, RUN and BUBBLE.
REQ-017 IDLE is entered on reset; the next edge SHALL go to RUN with no capture and PC unchanged.
REQ-018 In RUN with iStall=0 and iBranchTaken=0, each edge SHALL do: IR<=iInstruction, oInstrAddress<=PC, PC<=PC+1, oValid<=1.
REQ-019 PC increment SHALL be modulo 2^16: 0xFFFF wraps to 0x0000 with no flag.
REQ-020 iStall=1 without a branch SHALL hold PC, IR, oInstrAddress, oValid and state unchanged.
REQ-021 On iBranchTaken=1 in RUN or BUBBLE, the edge SHALL do: PC<=iBranchTarget, oValid<=0, state<=BUBBLE; IR contents are don't-care.
REQ-022 Branch SHALL take priority over stall when both are 1.
REQ-023 In BUBBLE with iStall=0 and no branch, the edge SHALL capture normally (per REQ-018) and go to RUN; fetch-to-decode latency is 1 cycle; a taken branch costs exactly 1 invalid cycle.
REQ-024 iBranchTaken and iStall SHALL be ignored in IDLE.
REQ-025 The block SHALL NOT interpret opcodes; NOP and unknown opcodes are passed through with oValid=1.

Reset
REQ-026 Reset=1 at an edge SHALL force PC=0x0000, IR=0, oInstrAddress=0x0000, oValid=0, state=IDLE, overriding stall and branch, including mid-bubble.
REQ-027 After reset release, the first oValid=1 cycle SHALL present the instruction at address 0, two edges after release.

Verification
REQ-028 Reset then free run with ROM words 0..5 -> oValid rises on the 2nd edge; oInstrAddress steps 0,1,2,... and fields match the ROM word bit-for-bit.
REQ-029 With ROM word 1 = {STO,R7,0x4800} -> oOperation=STO, oDestination=R7 code, oLiteral=0x4800.
REQ-030 iStall=1 for 3 cycles while PC=6 -> outputs frozen for 3 cycles, then address 6 decodes and PC resumes at 7 with no skip or repeat.
REQ-031 iBranchTaken=1 with target 8 while decoding address 10 -> next cycle oValid=0; following cycle oInstrAddress=8, oValid=1.
REQ-032 iBranchTaken=1 and iStall=1 together with target 2 -> branch taken (oValid=0, then address 2).
REQ-033 Force PC to 0xFFFF via branch -> decodes 0xFFFF, then 0x0000. Reset asserted during BUBBLE -> IDLE; oValid=0; restart from address 0.

Source files
------------

// File: rtl/instr_fetch_decode_if.sv
// rtl/instr_fetch_decode_if.sv - ROM, execute-feedback and decoded-field bundle for instr_fetch_decode
interface instr_fetch_decode_if;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        oValid;
    logic [3:0]  oOperation;
    logic [7:0]  oDestination;
    logic [7:0]  oSourceA;
    logic [7:0]  oSourceB;
    logic [15:0] oLiteral;
    logic [15:0] oInstrAddress;

    modport master (
        output iInstruction, iStall, iBranchTaken, iBranchTarget,
        input  oAddress, oValid, oOperation, oDestination, oSourceA, oSourceB,
               oLiteral, oInstrAddress
    );

    modport slave (
        input  iInstruction, iStall, iBranchTaken, iBranchTarget,
        output oAddress, oValid, oOperation, oDestination, oSourceA, oSourceB,
               oLiteral, oInstrAddress
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - PC/instruction-register fetch stage with stall, branch redirect and field decode
module instr_fetch_decode (
    input  logic                  Clock,
    input  logic                  Reset,
    instr_fetch_decode_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] pc;
    logic [27:0] ir;
    logic [15:0] instr_addr;
    logic        valid;

    logic        do_branch;
    logic        do_capture;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (bus.iBranchTaken) begin
                    state_nxt = BUBBLE;
                end
            end
            BUBBLE: begin
                if (bus.iBranchTaken) begin
                    state_nxt = BUBBLE;
                end else if (!bus.iStall) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Branch outranks stall: a redirect must never be lost behind a busy downstream.
    always_comb begin
        do_branch  = 1'b0;
        do_capture = 1'b0;
        case (state)
            RUN, BUBBLE: begin
                do_branch  = bus.iBranchTaken;
                do_capture = !bus.iBranchTaken && !bus.iStall;
            end
            default: begin
                do_branch  = 1'b0;
                do_capture = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc         <= 16'h0000;
            ir         <= 28'h0000000;
            instr_addr <= 16'h0000;
            valid      <= 1'b0;
        end else if (do_branch) begin
            pc    <= bus.iBranchTarget;
            valid <= 1'b0;
        end else if (do_capture) begin
            ir         <= bus.iInstruction;
            instr_addr <= pc;
            pc         <= pc + 16'h0001;
            valid      <= 1'b1;
        end
    end

    assign bus.oAddress      = pc;
    assign bus.oValid        = valid;
    assign bus.oInstrAddress = instr_addr;
    assign bus.oOperation    = ir[27:24];
    assign bus.oDestination  = ir[23:16];
    assign bus.oSourceA      = ir[15:8];
    assign bus.oSourceB      = ir[7:0];
    assign bus.oLiteral      = ir[15:0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - scoreboard bench for instr_fetch_decode
module tb_instr_fetch_decode;

    logic clk;
    logic Reset;

    instr_fetch_decode_if bus ();

    instr_fetch_decode dut (
        .Clock (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] OP_STO = 4'h3;

    function automatic logic [27:0] rom(input logic [15:0] a);
        if (a == 16'h0001) begin
            return {OP_STO, 8'h07, 16'h4800};
        end
        return {a[3:0] ^ 4'h5, a[7:0] + 8'h11, a[15:8] ^ 8'hA5, a[7:0] ^ 8'h3C};
    endfunction

    assign bus.iInstruction = rom(bus.oAddress);

    typedef struct {
        logic        valid;
        logic [15:0] addr;
        logic [27:0] word;
        logic        known;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // reference state
    int          m_state = 0;
    logic [15:0] m_pc    = 16'h0000;
    logic        m_valid = 1'b0;
    logic [15:0] m_addr  = 16'h0000;
    logic [27:0] m_word  = 28'h0;
    logic        m_known = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic stall, input logic br, input logic [15:0] tgt);
        exp_t e;
        @(negedge clk);
        Reset             = rst;
        bus.iStall        = stall;
        bus.iBranchTaken  = br;
        bus.iBranchTarget = tgt;

        if (rst) begin
            m_state = 0; m_pc = 16'h0; m_valid = 1'b0;
            m_addr  = 16'h0; m_word = 28'h0; m_known = 1'b1;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (br) begin
            m_pc = tgt; m_valid = 1'b0; m_known = 1'b0; m_state = 2;
        end else if (!stall) begin
            m_word = rom(m_pc); m_addr = m_pc; m_pc = m_pc + 16'h1;
            m_valid = 1'b1; m_known = 1'b1; m_state = 1;
        end
        e.valid = m_valid; e.addr = m_addr; e.word = m_word; e.known = m_known; e.pc = m_pc;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("valid", {31'd0, bus.oValid}, {31'd0, e.valid});
            check("pc", {16'd0, bus.oAddress}, {16'd0, e.pc});
            if (e.known) begin
                check("instr_addr", {16'd0, bus.oInstrAddress}, {16'd0, e.addr});
                check("op",  {28'd0, bus.oOperation},   {28'd0, e.word[27:24]});
                check("dst", {24'd0, bus.oDestination}, {24'd0, e.word[23:16]});
                check("sa",  {24'd0, bus.oSourceA},     {24'd0, e.word[15:8]});
                check("sb",  {24'd0, bus.oSourceB},     {24'd0, e.word[7:0]});
                check("lit", {16'd0, bus.oLiteral},     {16'd0, e.word[15:0]});
                if (e.valid && e.addr == 16'h0001) begin
                    check("sto_op",  {28'd0, bus.oOperation},   {28'd0, OP_STO});
                    check("sto_dst", {24'd0, bus.oDestination}, 32'h07);
                    check("sto_lit", {16'd0, bus.oLiteral},     32'h4800);
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        Reset             = 1'b1;
        bus.iStall        = 1'b0;
        bus.iBranchTaken  = 1'b0;
        bus.iBranchTarget = 16'h0;

        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h1234);

        // branch and stall in IDLE are ignored
        step(1'b0, 1'b1, 1'b1, 16'h0030);

        for (int i = 0; i < 20 && m_pc != 16'h0006; i++) run(1);
        check("reach_pc6", {16'd0, m_pc}, 32'h6);

        step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        run(1);

        for (int i = 0; i < 20 && !(m_valid && m_addr == 16'h000A); i++) run(1);
        check("reach_addr10", {16'd0, m_addr}, 32'hA);
        step(1'b0, 1'b0, 1'b1, 16'h0008);
        run(2);

        step(1'b0, 1'b1, 1'b1, 16'h0002);
        run(2);

        // back-to-back branch from BUBBLE, then PC wrap
        step(1'b0, 1'b0, 1'b1, 16'h0020);
        step(1'b0, 1'b0, 1'b1, 16'hFFFF);
        run(3);

        step(1'b0, 1'b0, 1'b1, 16'h0005);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        run(2);

        step(1'b0, 1'b0, 1'b1, 16'h0040);
        step(1'b1, 1'b1, 1'b1, 16'h0077);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        run(3);

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
